packet_arbiter: RTL and testbench
=================================

PACKET_ARBITER -- requirements
Module: packet_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, byte-lane width of all tdata ports.
REQ-002 Parameter FAIR, default 1, 1 = round-robin between inputs, 0 = fixed priority to input A.
REQ-003 i_clk  input  1  single clock, all logic rising-edge.
REQ-004 i_rst  input  1  synchronous, active-high reset.
REQ-005 i_a_tdata  input  DATA_WIDTH  input A payload byte.
REQ-006 i_a_tlast  input  1  input A last byte of packet.
REQ-007 i_a_tvalid  input  1  input A byte valid.
REQ-008 o_a_tready  output  1  input A byte accepted when high with i_a_tvalid.
REQ-009 i_b_tdata / i_b_tlast / i_b_tvalid / o_b_tready  same as REQ-005..008 for input B.
REQ-010 o_tdata  output  DATA_WIDTH  merged stream payload, feeds the UART emitter.
REQ-011 o_tlast  output  1  merged stream last byte of packet.
REQ-012 o_tvalid  output  1  merged stream byte valid.
REQ-013 i_tready  input  1  downstream (emitter) ready.

Function
REQ-014 Packets SHALL never interleave; once granted, an input owns the output until its tlast byte is accepted.
REQ-015 FSM states: IDLE, PASS_A, PASS_B.
REQ-016 IDLE: only A valid -> PASS_A; only B valid -> PASS_B; both valid -> input not equal to last_grant (FAIR=1) or A (FAIR=0); none -> stay.
REQ-017 Grant takes effect the cycle after the IDLE decision; both o_a_tready and o_b_tready are 0 while in IDLE.
REQ-018 PASS_x: o_x_tready = output register free (see REQ-021); the other input's tready = 0.
REQ-019 Accepting a byte with tlast=1 in PASS_x SHALL set last_grant = x and return to IDLE next cycle (one-cycle bubble between packets, including single-byte packets).
REQ-020 Output SHALL be one registered stage: an accepted input byte appears on o_tdata/o_tlast with o_tvalid=1 exactly one cycle later.
REQ-021 Output register free = !o_tvalid || i_tready; full throughput of one byte per cycle inside a packet while i_tready=1.
REQ-022 o_tdata/o_tlast SHALL hold stable while o_tvalid=1 and i_tready=0.
REQ-023 o_tvalid deasserts the cycle after the final held byte is taken if no new byte was accepted.
REQ-024 Input tvalid dropping mid-packet SHALL keep the grant (wait, no timeout); no bytes are dropped or duplicated.

Reset
REQ-025 On i_rst: state=IDLE, o_tvalid=0, o_tlast=0, o_tdata=0, last_grant=B (A wins first contention), both treadys=0.
REQ-026 Reset mid-packet SHALL discard any partially passed packet and the held output byte; no recovery of tail bytes.

Structure
REQ-027 The FSM state encoding and default DATA_WIDTH SHALL reside in the shared observer package.
REQ-028 The output register SHALL be a sub-module stream_reg (valid/ready pipeline register, DATA_WIDTH+1 wide).

Verification
REQ-029 A sends 3-byte packet 0x11,0x22,0x33(last), B idle, i_tready=1 -> output 0x11,0x22,0x33 on consecutive cycles, tlast on 0x33, first byte 2 cycles after i_a_tvalid.
REQ-030 A and B both valid from reset, FAIR=1, each repeating 2-byte packets -> output order A,B,A,B packets, never interleaved, one idle cycle between packets.
REQ-031 Same as REQ-030 with FAIR=0 -> only A packets pass while A stays valid; B o_b_tready stays 0.
REQ-032 i_tready toggled 1,0,0,1 during A packet 0xA0..0xA3 -> o_tdata held stable while stalled, all four bytes delivered once, in order.
REQ-033 Assert i_rst for one cycle after second byte of a 4-byte B packet -> next cycle o_tvalid=0, state IDLE; a subsequent A packet passes intact.
REQ-034 Back-to-back single-byte packets 0x55(last) on A, i_tready=1 -> one byte output every 2 cycles, each with o_tlast=1.

Source files
------------

// File: rtl/packet_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// packet_arbiter_pkg : shared FSM encoding and defaults for packet_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
package packet_arbiter_pkg;

  localparam int C_DATA_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PASS_A = 2'd1,
    ST_PASS_B = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

endpackage
`default_nettype wire

// File: rtl/packet_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// packet_arbiter_if : two input byte streams plus the merged output stream
// Rev 1.0
// ---------------------------------------------------------------------------
interface packet_arbiter_if import packet_arbiter_pkg::*; #(
  parameter int DATA_WIDTH = C_DATA_WIDTH_DEFAULT
) ();

  logic [DATA_WIDTH-1:0] i_a_tdata;
  logic                  i_a_tlast;
  logic                  i_a_tvalid;
  logic                  o_a_tready;

  logic [DATA_WIDTH-1:0] i_b_tdata;
  logic                  i_b_tlast;
  logic                  i_b_tvalid;
  logic                  o_b_tready;

  logic [DATA_WIDTH-1:0] o_tdata;
  logic                  o_tlast;
  logic                  o_tvalid;
  logic                  i_tready;

  // Environment side: sources for A/B and the downstream sink
  modport master (
    output i_a_tdata, i_a_tlast, i_a_tvalid,
    input  o_a_tready,
    output i_b_tdata, i_b_tlast, i_b_tvalid,
    input  o_b_tready,
    input  o_tdata, o_tlast, o_tvalid,
    output i_tready
  );

  modport slave (
    input  i_a_tdata, i_a_tlast, i_a_tvalid,
    output o_a_tready,
    input  i_b_tdata, i_b_tlast, i_b_tvalid,
    output o_b_tready,
    output o_tdata, o_tlast, o_tvalid,
    input  i_tready
  );

endinterface
`default_nettype wire

// File: rtl/packet_arbiter_stream_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stream_reg : single-stage valid/ready pipeline register, full throughput
// Rev 1.0
// ---------------------------------------------------------------------------
module stream_reg #(
  parameter int WIDTH = 9
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  logic             valid_q;
  logic             valid_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             w_free;

  // Register may reload in the same cycle its current word is taken
  assign w_free = !valid_q || i_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (w_free) begin
      valid_d = i_valid;
      if (i_valid) begin
        data_d = i_data;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign o_ready = w_free;
  assign o_valid = valid_q;
  assign o_data  = data_q;

endmodule
`default_nettype wire

// File: rtl/packet_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// packet_arbiter : merges two packet streams without interleaving packets
// Rev 1.0
// ---------------------------------------------------------------------------
module packet_arbiter import packet_arbiter_pkg::*; #(
  parameter int DATA_WIDTH = C_DATA_WIDTH_DEFAULT,
  parameter int FAIR       = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  packet_arbiter_if.slave  bus
);

  arb_state_e state_q;
  arb_state_e state_d;
  grant_e     last_grant_q;
  grant_e     last_grant_d;

  logic                  w_reg_ready;
  logic                  w_acc_a;
  logic                  w_acc_b;
  logic                  w_in_valid;
  logic [DATA_WIDTH:0]   w_in_data;
  logic                  w_out_valid;
  logic [DATA_WIDTH:0]   w_out_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_B;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_a_tvalid && bus.i_b_tvalid) begin
          // Contention: alternate when fair, otherwise A always wins
          if ((FAIR != 0) && (last_grant_q == GRANT_A)) begin
            state_d = ST_PASS_B;
          end else begin
            state_d = ST_PASS_A;
          end
        end else if (bus.i_a_tvalid) begin
          state_d = ST_PASS_A;
        end else if (bus.i_b_tvalid) begin
          state_d = ST_PASS_B;
        end
      end
      ST_PASS_A: begin
        if (w_acc_a && bus.i_a_tlast) begin
          state_d      = ST_IDLE;
          last_grant_d = GRANT_A;
        end
      end
      ST_PASS_B: begin
        if (w_acc_b && bus.i_b_tlast) begin
          state_d      = ST_IDLE;
          last_grant_d = GRANT_B;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    bus.o_a_tready = (state_q == ST_PASS_A) && w_reg_ready;
    bus.o_b_tready = (state_q == ST_PASS_B) && w_reg_ready;
    w_acc_a        = bus.i_a_tvalid && bus.o_a_tready;
    w_acc_b        = bus.i_b_tvalid && bus.o_b_tready;
    w_in_valid     = w_acc_a || w_acc_b;
    if (state_q == ST_PASS_B) begin
      w_in_data = {bus.i_b_tlast, bus.i_b_tdata};
    end else begin
      w_in_data = {bus.i_a_tlast, bus.i_a_tdata};
    end
  end

  stream_reg #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_out_reg (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (w_in_valid),
    .o_ready (w_reg_ready),
    .i_data  (w_in_data),
    .o_valid (w_out_valid),
    .i_ready (bus.i_tready),
    .o_data  (w_out_data)
  );

  assign bus.o_tvalid = w_out_valid;
  assign bus.o_tdata  = w_out_data[DATA_WIDTH-1:0];
  assign bus.o_tlast  = w_out_data[DATA_WIDTH];

endmodule
`default_nettype wire

// File: tb/tb_packet_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_packet_arbiter : directed checks of packet_arbiter (fair and fixed priority)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_packet_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  packet_arbiter_if #(.DATA_WIDTH(8)) bus_f ();
  packet_arbiter_if #(.DATA_WIDTH(8)) bus_p ();

  packet_arbiter #(.DATA_WIDTH(8), .FAIR(1)) dut_f (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_f.slave)
  );

  packet_arbiter #(.DATA_WIDTH(8), .FAIR(0)) dut_p (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_p.slave)
  );

  // The fixed-priority instance sees exactly the same stimulus
  assign bus_p.i_a_tdata  = bus_f.i_a_tdata;
  assign bus_p.i_a_tlast  = bus_f.i_a_tlast;
  assign bus_p.i_a_tvalid = bus_f.i_a_tvalid;
  assign bus_p.i_b_tdata  = bus_f.i_b_tdata;
  assign bus_p.i_b_tlast  = bus_f.i_b_tlast;
  assign bus_p.i_b_tvalid = bus_f.i_b_tvalid;
  assign bus_p.i_tready   = bus_f.i_tready;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // sel 0 = fair instance, 1 = fixed-priority instance
  task automatic chk_out(input string tag, input int sel, input bit ev,
                         input logic [7:0] ed, input bit el);
    logic       v;
    logic       l;
    logic [7:0] d;
    if (sel == 0) begin
      v = bus_f.o_tvalid; d = bus_f.o_tdata; l = bus_f.o_tlast;
    end else begin
      v = bus_p.o_tvalid; d = bus_p.o_tdata; l = bus_p.o_tlast;
    end
    chk_bit({tag, "_valid"}, v, ev);
    if (ev) begin
      chk_byte({tag, "_data"}, d, ed);
      chk_bit({tag, "_last"}, l, el);
    end
  endtask

  task automatic chk_rdy(input string tag, input int sel, input bit ea, input bit eb);
    if (sel == 0) begin
      chk_bit({tag, "_a_rdy"}, bus_f.o_a_tready, ea);
      chk_bit({tag, "_b_rdy"}, bus_f.o_b_tready, eb);
    end else begin
      chk_bit({tag, "_a_rdy"}, bus_p.o_a_tready, ea);
      chk_bit({tag, "_b_rdy"}, bus_p.o_b_tready, eb);
    end
  endtask

  task automatic drive_a(input bit v, input logic [7:0] d, input bit l);
    bus_f.i_a_tvalid = v;
    bus_f.i_a_tdata  = d;
    bus_f.i_a_tlast  = l;
  endtask

  task automatic drive_b(input bit v, input logic [7:0] d, input bit l);
    bus_f.i_b_tvalid = v;
    bus_f.i_b_tdata  = d;
    bus_f.i_b_tlast  = l;
  endtask

  // Leaves the bench one cycle before the first post-reset edge
  task automatic do_reset();
    rst = 1'b1;
    drive_a(1'b0, 8'h00, 1'b0);
    drive_b(1'b0, 8'h00, 1'b0);
    bus_f.i_tready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    drive_a(1'b0, 8'h00, 1'b0);
    drive_b(1'b0, 8'h00, 1'b0);
    bus_f.i_tready = 1'b0;

    // Reset state, with inputs active to show readies stay low
    rst = 1'b1;
    tick();
    tick();
    drive_a(1'b1, 8'h99, 1'b1);
    drive_b(1'b1, 8'h98, 1'b1);
    bus_f.i_tready = 1'b1;
    settle();
    chk_out("rst", 0, 1'b0, 8'h00, 1'b0);
    chk_byte("rst_tdata", bus_f.o_tdata, 8'h00);
    chk_bit("rst_tlast", bus_f.o_tlast, 1'b0);
    chk_rdy("rst", 0, 1'b0, 1'b0);

    // Three-byte packet on A, B idle
    do_reset();
    drive_a(1'b1, 8'h11, 1'b0);
    bus_f.i_tready = 1'b1;
    settle();
    chk_rdy("t1_idle", 0, 1'b0, 1'b0);
    tick();
    chk_out("t1_c1", 0, 1'b0, 8'h00, 1'b0);
    chk_rdy("t1_c1", 0, 1'b1, 1'b0);
    tick();
    chk_out("t1_b0", 0, 1'b1, 8'h11, 1'b0);
    drive_a(1'b1, 8'h22, 1'b0);
    tick();
    chk_out("t1_b1", 0, 1'b1, 8'h22, 1'b0);
    drive_a(1'b1, 8'h33, 1'b1);
    tick();
    chk_out("t1_b2", 0, 1'b1, 8'h33, 1'b1);
    drive_a(1'b0, 8'h00, 1'b0);
    settle();
    chk_rdy("t1_back_idle", 0, 1'b0, 1'b0);
    tick();
    chk_out("t1_drain", 0, 1'b0, 8'h00, 1'b0);

    // Both inputs contending, round-robin
    do_reset();
    drive_a(1'b1, 8'h1A, 1'b0);
    drive_b(1'b1, 8'h2A, 1'b0);
    bus_f.i_tready = 1'b1;
    tick();
    chk_out("t2_c1", 0, 1'b0, 8'h00, 1'b0);
    chk_rdy("t2_c1", 0, 1'b1, 1'b0);
    tick();
    chk_out("t2_a0", 0, 1'b1, 8'h1A, 1'b0);
    drive_a(1'b1, 8'h1B, 1'b1);
    tick();
    chk_out("t2_a1", 0, 1'b1, 8'h1B, 1'b1);
    drive_a(1'b1, 8'h1A, 1'b0);
    settle();
    chk_rdy("t2_c3", 0, 1'b0, 1'b0);
    tick();
    chk_out("t2_bubble1", 0, 1'b0, 8'h00, 1'b0);
    chk_rdy("t2_c4", 0, 1'b0, 1'b1);
    tick();
    chk_out("t2_b0", 0, 1'b1, 8'h2A, 1'b0);
    drive_b(1'b1, 8'h2B, 1'b1);
    tick();
    chk_out("t2_b1", 0, 1'b1, 8'h2B, 1'b1);
    drive_b(1'b1, 8'h2A, 1'b0);
    tick();
    chk_out("t2_bubble2", 0, 1'b0, 8'h00, 1'b0);
    chk_rdy("t2_c7", 0, 1'b1, 1'b0);
    tick();
    chk_out("t2_a0_again", 0, 1'b1, 8'h1A, 1'b0);

    // Same contention, fixed-priority instance: A keeps winning
    do_reset();
    drive_a(1'b1, 8'h1A, 1'b0);
    drive_b(1'b1, 8'h2A, 1'b0);
    bus_f.i_tready = 1'b1;
    tick();
    chk_rdy("t3_c1", 1, 1'b1, 1'b0);
    tick();
    chk_out("t3_a0", 1, 1'b1, 8'h1A, 1'b0);
    drive_a(1'b1, 8'h1B, 1'b1);
    tick();
    chk_out("t3_a1", 1, 1'b1, 8'h1B, 1'b1);
    drive_a(1'b1, 8'h1A, 1'b0);
    tick();
    chk_out("t3_bubble", 1, 1'b0, 8'h00, 1'b0);
    chk_rdy("t3_c4", 1, 1'b1, 1'b0);
    tick();
    chk_out("t3_a0_again", 1, 1'b1, 8'h1A, 1'b0);
    drive_a(1'b1, 8'h1B, 1'b1);
    tick();
    chk_out("t3_a1_again", 1, 1'b1, 8'h1B, 1'b1);
    chk_bit("t3_b_rdy_low", bus_p.o_b_tready, 1'b0);

    // Downstream stalls during an A packet: tready 1,0,0,1
    do_reset();
    drive_a(1'b1, 8'hA0, 1'b0);
    bus_f.i_tready = 1'b1;
    tick();
    chk_rdy("t4_c1", 0, 1'b1, 1'b0);
    tick();
    chk_out("t4_c2", 0, 1'b1, 8'hA0, 1'b0);
    drive_a(1'b1, 8'hA1, 1'b0);
    tick();
    chk_out("t4_c3", 0, 1'b1, 8'hA1, 1'b0);
    drive_a(1'b1, 8'hA2, 1'b0);
    bus_f.i_tready = 1'b0;
    settle();
    chk_rdy("t4_stall", 0, 1'b0, 1'b0);
    tick();
    chk_out("t4_hold1", 0, 1'b1, 8'hA1, 1'b0);
    tick();
    chk_out("t4_hold2", 0, 1'b1, 8'hA1, 1'b0);
    bus_f.i_tready = 1'b1;
    settle();
    chk_rdy("t4_resume", 0, 1'b1, 1'b0);
    tick();
    chk_out("t4_c6", 0, 1'b1, 8'hA2, 1'b0);
    drive_a(1'b1, 8'hA3, 1'b1);
    tick();
    chk_out("t4_c7", 0, 1'b1, 8'hA3, 1'b1);
    drive_a(1'b0, 8'h00, 1'b0);
    tick();
    chk_out("t4_drain", 0, 1'b0, 8'h00, 1'b0);

    // Reset after the second byte of a B packet, then an A packet
    do_reset();
    drive_b(1'b1, 8'hB0, 1'b0);
    bus_f.i_tready = 1'b1;
    tick();
    chk_rdy("t5_c1", 0, 1'b0, 1'b1);
    tick();
    chk_out("t5_b0", 0, 1'b1, 8'hB0, 1'b0);
    drive_b(1'b1, 8'hB1, 1'b0);
    tick();
    chk_out("t5_b1", 0, 1'b1, 8'hB1, 1'b0);
    drive_b(1'b1, 8'hB2, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_out("t5_after_rst", 0, 1'b0, 8'h00, 1'b0);
    chk_byte("t5_after_rst_tdata", bus_f.o_tdata, 8'h00);
    drive_b(1'b0, 8'h00, 1'b0);
    drive_a(1'b1, 8'hC1, 1'b0);
    settle();
    chk_rdy("t5_idle", 0, 1'b0, 1'b0);
    tick();
    chk_out("t5_c5", 0, 1'b0, 8'h00, 1'b0);
    chk_rdy("t5_c5", 0, 1'b1, 1'b0);
    tick();
    chk_out("t5_c1", 0, 1'b1, 8'hC1, 1'b0);
    drive_a(1'b1, 8'hC2, 1'b1);
    tick();
    chk_out("t5_c2", 0, 1'b1, 8'hC2, 1'b1);
    drive_a(1'b0, 8'h00, 1'b0);
    tick();
    chk_out("t5_drain", 0, 1'b0, 8'h00, 1'b0);

    // Back-to-back single-byte packets: one byte every two cycles
    do_reset();
    drive_a(1'b1, 8'h55, 1'b1);
    bus_f.i_tready = 1'b1;
    tick();
    for (int k = 2; k <= 7; k++) begin
      tick();
      chk_out($sformatf("t6_c%0d", k), 0, (k % 2) == 0, 8'h55, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
